dm: RTL and testbench
=====================

# dm

Data-memory stage of the five-stage MIPS pipeline: consumes the EX/MEM-latched ALU result as a byte address, performs word/half/byte stores on the clock edge, and returns sign- or zero-extended load data combinationally to the MEM/WB register. It is the direct downstream consumer of the ALU's `result`. It also emits one grader-visible log line per committed store.

## Interface
Parameters:
- `DEPTH`, 3072: memory size in 32-bit words. Covers byte addresses 0x0000_0000–0x0000_2FFF.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high. Clears every word to 0.
- `PC` input 32: PC of the instruction in MEM. Used only for the store log.
- `A` input 32: byte address, the ALU result latched in EX/MEM.
- `WD` input 32: store data, the forwarded rt value. Low byte or half is used for `sb`/`sh`.
- `MemWrite` input 1: store request for this cycle.
- `DMOp` input 3: access type. Values are `DM_w`=0, `DM_hu`=1, `DM_h`=2, `DM_bu`=3, `DM_b`=4.
- `RD` output 32: load data after extension. Combinational.
- `AddrExc` output 1: access is misaligned or out of range. Combinational.

## Operation
- Word index `idx = A[13:2]`. Byte offset `off = A[1:0]`.
- **Alignment:**
  - Word accesses need `off == 0`.
  - Half accesses need `off[0] == 0`.
  - Byte accesses are always aligned.
- **Range:** `A >= 4*DEPTH` is out of range.
- **Invalid `DMOp`:** values 5–7 are treated as an exception.
- **Exception** = misaligned OR out of range OR invalid `DMOp`.
  - `AddrExc` = exception.
  - `RD` = 0.
  - A store in that cycle is suppressed: no memory change, no log line.
- **Stores:** on a `MemWrite` edge with no exception, the byte enable `BE[3:0]` is:
  - word: `1111`.
  - half: `0011 << off`.
  - byte: `0001 << off`.
  - Signed and unsigned variants store identically.
- **Write data:** lanes are replicated before masking.
  - half: `{WD[15:0], WD[15:0]}`.
  - byte: `{4{WD[7:0]}}`.
  - Only enabled bytes of `mem[idx]` change.
- **Loads:** `RD` is always driven, independent of `MemWrite`.
  - word: `mem[idx]`.
  - half: the selected halfword, zero-extended (`DM_hu`) or sign-extended (`DM_h`).
  - byte: the selected byte, zero-extended (`DM_bu`) or sign-extended (`DM_b`).
- **Store log:** one `$display` per committed store, printed at the edge, in the form `"%d@%h: *%h <= %h"`.
  - Fields: `$time`, `PC`, word-aligned address (`{A[31:2],2'b00}`), full 32-bit word after merging.
  - No log line for reset, suppressed stores, or loads.

## Timing
- Read latency 0: `RD` and `AddrExc` follow `A` and `DMOp` in the same cycle.
- Write latency 1: a store is visible on `RD` in the cycle after its edge.
- Read-during-write to the same word: `RD` shows the old contents until the edge.
- Reset has priority over `MemWrite`:
  - A store presented in a reset cycle is discarded and not logged.
  - After the reset edge, every word reads 0.
- Reset values: all memory words 0. `RD` and `AddrExc` are combinational and have no reset value of their own.
- Back-to-back stores to the same word in consecutive cycles each merge into the previous result. Two `sb`s to offsets 0 and 1 both survive.
- No handshake and no stall output. The pipeline guarantees one access per cycle.

## Structure
- `def.v` gains `DM_w`, `DM_hu`, `DM_h`, `DM_bu` and `DM_b` alongside the existing ALU opcodes. The control unit and this block share them.
- One combinational sub-module, `dm_ext`: takes `DMOp`, `off` and the raw word, and produces `BE`, the replicated write data and the extended `RD`.
- The memory array and the log stay in `dm`.

## Test plan
- Reset, `sw` 0x12345678 @0x0, then `lw` @0x0 → `RD`=0x12345678. Log line shows `*00000000 <= 12345678`.
- `sb` 0xAB @0x5, then `sb` 0xCD @0x6 → `lw` @0x4 = 0x00CDAB00. `lb` @0x5 = 0xFFFFFFAB. `lbu` @0x5 = 0x000000AB.
- `sh` 0x8001 @0xA → `lh` @0xA = 0xFFFF8001. `lhu` @0xA = 0x00008001. `lw` @0x8 = 0x80010000.
- `sw` @0x2 (misaligned) and `sw` @0x3000 (out of range) → `AddrExc`=1, `RD`=0, memory unchanged, no log lines.
- `sw` 0xFFFFFFFF @0x10 asserted in the same cycle as `reset`=1 → `lw` @0x10 = 0, no log line.
- Same cycle: `sw` 0x11 @0x20 with a read of @0x20 → `RD` shows the old value (0). The next cycle shows 0x00000011.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory stage: access-type codes and helpers.
package dm_pkg;

  localparam int DM_DEPTH_DEF = 3072;
  localparam int DM_OP_W      = 3;

  // Access-type codes shared with the control unit.
  typedef enum logic [DM_OP_W-1:0] {
    DM_w  = 3'd0,
    DM_hu = 3'd1,
    DM_h  = 3'd2,
    DM_bu = 3'd3,
    DM_b  = 3'd4
  } dm_op_e;

  // Merge new byte lanes into an old word under a byte-enable mask.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Pipeline-side bus of the data-memory stage.
interface dm_if;
  import dm_pkg::*;

  logic [31:0]         PC;
  logic [31:0]         A;
  logic [31:0]         WD;
  logic                MemWrite;
  logic [DM_OP_W-1:0]  DMOp;
  logic [31:0]         RD;
  logic                AddrExc;

  // The pipeline drives the request, the memory stage answers.
  modport master (output PC, A, WD, MemWrite, DMOp, input RD, AddrExc);
  modport slave  (input PC, A, WD, MemWrite, DMOp, output RD, AddrExc);
endinterface

// File: rtl/dm_ext.sv
// Lane steering for the data memory: byte enables, replicated store data and
// extended load data for the selected access type and byte offset.
module dm_ext
  import dm_pkg::*;
(
  input  logic [DM_OP_W-1:0] dm_op_i,
  input  logic [1:0]         off_i,
  input  logic [31:0]        wd_i,
  input  logic [31:0]        raw_i,
  output logic [3:0]         be_o,
  output logic [31:0]        wdata_o,
  output logic [31:0]        rd_o
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Pick the addressed halfword and byte out of the raw word.
  always_comb begin
    half_s = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (off_i)
      2'd0:    byte_s = raw_i[7:0];
      2'd1:    byte_s = raw_i[15:8];
      2'd2:    byte_s = raw_i[23:16];
      2'd3:    byte_s = raw_i[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Decode the access type into enables, write lanes and load extension.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rd_o    = 32'h0000_0000;
    case (dm_op_i)
      DM_w: begin
        be_o    = 4'b1111;
        wdata_o = wd_i;
        rd_o    = raw_i;
      end
      DM_hu: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {wd_i[15:0], wd_i[15:0]};
        rd_o    = {16'h0000, half_s};
      end
      DM_h: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {wd_i[15:0], wd_i[15:0]};
        rd_o    = {{16{half_s[15]}}, half_s};
      end
      DM_bu: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wd_i[7:0]}};
        rd_o    = {24'h00_0000, byte_s};
      end
      DM_b: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wd_i[7:0]}};
        rd_o    = {{24{byte_s[7]}}, byte_s};
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rd_o    = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dm.sv
// Data-memory stage: combinational loads, byte-enabled stores on the rising
// edge, address exception detection and a log line per committed store.
module dm
  import dm_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);

  localparam logic [31:0] RANGE_LIMIT = 32'(4 * DEPTH);

  logic [31:0] mem_q [0:DEPTH-1];

  logic [11:0] idx_s;
  logic [1:0]  off_s;
  logic        in_range_s;
  logic        aligned_s;
  logic        op_ok_s;
  logic        exc_s;
  logic [31:0] raw_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] rd_ext_s;
  logic        commit_d;
  logic [31:0] word_d;

  // Address split, range check and fetch of the addressed word.
  always_comb begin
    idx_s      = bus.A[13:2];
    off_s      = bus.A[1:0];
    in_range_s = (bus.A < RANGE_LIMIT);
    raw_s      = in_range_s ? mem_q[idx_s] : 32'h0000_0000;
  end

  // Alignment rules per access type; unknown codes raise the exception.
  always_comb begin
    aligned_s = 1'b1;
    op_ok_s   = 1'b1;
    case (bus.DMOp)
      DM_w:        aligned_s = (off_s == 2'd0);
      DM_hu, DM_h: aligned_s = (off_s[0] == 1'b0);
      DM_bu, DM_b: aligned_s = 1'b1;
      default: begin
        aligned_s = 1'b1;
        op_ok_s   = 1'b0;
      end
    endcase
  end

  dm_ext u_ext (
    .dm_op_i (bus.DMOp),
    .off_i   (off_s),
    .wd_i    (bus.WD),
    .raw_i   (raw_s),
    .be_o    (be_s),
    .wdata_o (wdata_s),
    .rd_o    (rd_ext_s)
  );

  // Exception gating of the load result and the store commit, plus the merged word.
  always_comb begin
    exc_s    = ~aligned_s | ~in_range_s | ~op_ok_s;
    commit_d = bus.MemWrite & ~exc_s;
    word_d   = merge_word(raw_s, wdata_s, be_s);
  end

  assign bus.RD      = exc_s ? 32'h0000_0000 : rd_ext_s;
  assign bus.AddrExc = exc_s;

  // Memory array: reset clears every word and wins over a store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (commit_d) begin
      mem_q[idx_s] <= word_d;
      $display("%d@%h: *%h <= %h", $time, bus.PC, {bus.A[31:2], 2'b00}, word_d);
    end
  end

endmodule

// File: tb/tb_dm.sv
// Directed bench for the data-memory stage with a queue-based scoreboard.
module tb_dm;
  import dm_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        exc;
  } exp_t;

  logic clk;
  logic reset;
  logic chk_v;
  int   n_assert;
  int   n_fail;
  exp_t exp_q[$];

  dm_if bus ();

  dm #(.DEPTH(3072)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the edge; optionally queue an expectation.
  task automatic step(input logic rst, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic chk, input logic [31:0] erd, input logic eexc,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.MemWrite = we;
    bus.DMOp     = op;
    bus.A        = a;
    bus.WD       = wd;
    bus.PC       = 32'h0040_0000 + a;
    chk_v        = chk;
    if (chk) begin
      e.nm  = nm;
      e.rd  = erd;
      e.exc = eexc;
      exp_q.push_back(e);
    end
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] erd, input logic eexc, input string nm);
    step(1'b0, 1'b0, op, a, 32'h0000_0000, 1'b1, erd, eexc, nm);
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, op, a, wd, 1'b0, 32'h0000_0000, 1'b0, "");
  endtask

  // Monitor: mid-cycle, pop the oldest expectation and compare the DUT outputs.
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        n_assert = n_assert + 1;
        n_fail   = n_fail + 1;
        $display("FAIL scoreboard: check requested with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_assert = n_assert + 1;
        if (bus.RD !== e.rd) begin
          n_fail = n_fail + 1;
          $display("FAIL %s RD: got %h expected %h", e.nm, bus.RD, e.rd);
        end
        n_assert = n_assert + 1;
        if (bus.AddrExc !== e.exc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s AddrExc: got %b expected %b", e.nm, bus.AddrExc, e.exc);
        end
      end
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    chk_v        = 1'b0;
    reset        = 1'b1;
    bus.MemWrite = 1'b0;
    bus.DMOp     = DM_w;
    bus.A        = 32'h0000_0000;
    bus.WD       = 32'h0000_0000;
    bus.PC       = 32'h0000_0000;

    step(1'b1, 1'b0, DM_w, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    ld(DM_w, 32'h0000_0000, 32'h0000_0000, 1'b0, "reset_lw0");
    ld(DM_w, 32'h0000_2FFC, 32'h0000_0000, 1'b0, "reset_lw_top");

    // Word store; same-cycle read shows the old contents.
    step(1'b0, 1'b1, DM_w, 32'h0, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, "sw0_old");
    ld(DM_w,  32'h0000_0000, 32'h1234_5678, 1'b0, "lw0");
    ld(DM_bu, 32'h0000_0003, 32'h0000_0012, 1'b0, "lbu3");

    // Byte stores back to back into one word, high WD bits must be ignored.
    st(DM_b,  32'h0000_0005, 32'hDEAD_BEAB);
    st(DM_bu, 32'h0000_0006, 32'h1234_56CD);
    ld(DM_w,  32'h0000_0004, 32'h00CD_AB00, 1'b0, "lw4");
    ld(DM_b,  32'h0000_0005, 32'hFFFF_FFAB, 1'b0, "lb5");
    ld(DM_bu, 32'h0000_0005, 32'h0000_00AB, 1'b0, "lbu5");
    ld(DM_b,  32'h0000_0006, 32'hFFFF_FFCD, 1'b0, "lb6");

    // Halfword stores to both halves of one word.
    st(DM_h,  32'h0000_000A, 32'hFFFF_8001);
    ld(DM_h,  32'h0000_000A, 32'hFFFF_8001, 1'b0, "lhA");
    ld(DM_hu, 32'h0000_000A, 32'h0000_8001, 1'b0, "lhuA");
    ld(DM_w,  32'h0000_0008, 32'h8001_0000, 1'b0, "lw8");
    st(DM_hu, 32'h0000_0008, 32'hABCD_1234);
    ld(DM_w,  32'h0000_0008, 32'h8001_1234, 1'b0, "lw8_merged");
    ld(DM_b,  32'h0000_0009, 32'h0000_0012, 1'b0, "lb9");

    // Exceptions: misaligned, out of range, invalid op; stores suppressed.
    step(1'b0, 1'b1, DM_w, 32'h2, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 1'b1, "sw_misaligned");
    ld(DM_w, 32'h0000_0000, 32'h1234_5678, 1'b0, "lw0_after_misaligned");
    step(1'b0, 1'b1, DM_w, 32'h3000, 32'hBBBB_BBBB, 1'b1, 32'h0000_0000, 1'b1, "sw_out_of_range");
    ld(DM_w, 32'h0000_0000, 32'h1234_5678, 1'b0, "lw0_after_oor");
    ld(DM_w, 32'h0000_2FFC, 32'h0000_0000, 1'b0, "lw_top_after_oor");
    ld(DM_h, 32'h0000_0001, 32'h0000_0000, 1'b1, "lh_misaligned");
    ld(DM_b, 32'h0000_3000, 32'h0000_0000, 1'b1, "lb_oor");
    ld(3'd5, 32'h0000_0000, 32'h0000_0000, 1'b1, "op5");
    ld(3'd7, 32'h0000_0000, 32'h0000_0000, 1'b1, "op7");
    st(DM_w, 32'h0000_2FFC, 32'h0000_0055);
    ld(DM_w, 32'h0000_2FFC, 32'h0000_0055, 1'b0, "lw_top");

    // Read during write to the same word.
    step(1'b0, 1'b1, DM_w, 32'h20, 32'h0000_0011, 1'b1, 32'h0000_0000, 1'b0, "rdw_old");
    ld(DM_w, 32'h0000_0020, 32'h0000_0011, 1'b0, "rdw_new");

    // Store in a reset cycle is discarded; reset clears the whole array.
    st(DM_w, 32'h0000_0010, 32'h0000_0077);
    ld(DM_w, 32'h0000_0010, 32'h0000_0077, 1'b0, "lw10_pre");
    step(1'b1, 1'b1, DM_w, 32'h10, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "");
    ld(DM_w, 32'h0000_0010, 32'h0000_0000, 1'b0, "lw10_after_reset");
    ld(DM_w, 32'h0000_0000, 32'h0000_0000, 1'b0, "lw0_after_reset");
    ld(DM_w, 32'h0000_0020, 32'h0000_0000, 1'b0, "lw20_after_reset");

    step(1'b0, 1'b0, DM_w, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    @(posedge clk);
    n_assert = n_assert + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
